// File: rtl/adder_ring_counter_if.sv
// Control/result bundle between the measurement wrapper (master) and the ring counter (slave).
// Carries enable/start/window in, the async ring tap in, and ring enable, status and held result out.
interface adder_ring_counter_if #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 16
);
  logic             active;
  logic             start;
  logic [WIN_W-1:0] window;
  logic             chain_out;
  logic             ring_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] count;
  logic             overflow;

  modport master (
    output active, start, window, chain_out,
    input  ring_en, busy, done, count, overflow
  );

  modport slave (
    input  active, start, window, chain_out,
    output ring_en, busy, done, count, overflow
  );
endinterface

// File: rtl/adder_ring_counter.sv
// Gates the adder ring oscillator for a programmable window and counts synchronised chain_out rises.
// done pulses SETTLE_CYC+window+3 edges after start; no backpressure, start ignored while busy, active low aborts.
module adder_ring_counter #(
  parameter int WIN_W      = 16,
  parameter int CNT_W      = 16,
  parameter int SETTLE_CYC = 4
) (
  input logic                 wb_clk_i,
  input logic                 wb_rst_n,
  adder_ring_counter_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [WIN_W-1:0] SETTLE_LAST = WIN_W'(SETTLE_CYC - 1);
  localparam logic [WIN_W-1:0] DRAIN_LAST  = WIN_W'(2);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q;
  logic [WIN_W-1:0] win_q;
  logic [WIN_W-1:0] tmr_q;
  logic             ring_en_q;
  logic             busy_q;
  logic             done_q;
  logic [CNT_W-1:0] count_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sat_q, sat_d;
  logic [2:0]       sync_q;
  logic [1:0]       gate_q;
  logic             launch;
  logic             rise;

  assign launch = (state_q == S_IDLE) && bus.active && bus.start;
  assign rise   = sync_q[1] & ~sync_q[2];

  assign bus.ring_en  = ring_en_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

  // Two gate flops plus the counter register give the same 3-cycle delay as the synchroniser path.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      sync_q <= '0;
      gate_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.chain_out};
      gate_q <= (state_q == S_IDLE) ? 2'b00 : {gate_q[0], state_q == S_COUNT};
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (launch) begin
      cnt_d = '0;
      sat_d = 1'b0;
    end else if ((state_q != S_IDLE) && gate_q[1] && rise) begin
      if (cnt_q == CNT_MAX) sat_d = 1'b1;
      else                  cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q   <= S_IDLE;
      win_q     <= '0;
      tmr_q     <= '0;
      ring_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
    end else if (!bus.active) begin
      state_q   <= S_IDLE;
      ring_en_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            win_q     <= bus.window;
            tmr_q     <= SETTLE_LAST;
            ring_en_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
          end else if (win_q == '0) begin
            tmr_q     <= DRAIN_LAST;
            ring_en_q <= 1'b0;
            state_q   <= S_DRAIN;
          end else begin
            tmr_q   <= win_q - 1'b1;
            state_q <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
          end else begin
            tmr_q     <= DRAIN_LAST;
            ring_en_q <= 1'b0;
            state_q   <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (tmr_q != '0) begin
            tmr_q <= tmr_q - 1'b1;
          end else begin
            done_q  <= 1'b1;
            count_q <= cnt_q;
            ovf_q   <= sat_q;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_ring_counter.sv
// Directed vector bench for adder_ring_counter: a 16-bit-count instance and a 4-bit-count instance.
module tb_adder_ring_counter;

  logic clk;
  logic rst_n;

  adder_ring_counter_if #(.WIN_W(16), .CNT_W(16)) ifc0 ();
  adder_ring_counter_if #(.WIN_W(16), .CNT_W(4))  ifc1 ();

  adder_ring_counter #(.WIN_W(16), .CNT_W(16), .SETTLE_CYC(4)) u0 (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (ifc0)
  );

  adder_ring_counter #(.WIN_W(16), .CNT_W(4), .SETTLE_CYC(4)) u1 (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .bus      (ifc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Clock-synchronous square wave standing in for the ring tap; period 0 holds it low.
  int   wave_per = 0;
  int   ph = 0;
  logic chain = 1'b0;
  always @(posedge clk) begin
    ph    <= ph + 1;
    chain <= (wave_per == 0) ? 1'b0 : ((ph % wave_per) < (wave_per / 2));
  end
  assign ifc0.chain_out = chain;
  assign ifc1.chain_out = chain;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int d_n[2]    = '{0, 0};
  int d_edge[2] = '{0, 0};
  int ring_n[2] = '{0, 0};
  always @(negedge clk) begin
    if (ifc0.done) begin d_n[0]++; d_edge[0] = edge_n; end
    if (ifc1.done) begin d_n[1]++; d_edge[1] = edge_n; end
    if (ifc0.ring_en) ring_n[0]++;
    if (ifc1.ring_en) ring_n[1]++;
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic int get_cnt(input int d);
    return (d == 0) ? int'(ifc0.count) : int'(ifc1.count);
  endfunction
  function automatic int get_ovf(input int d);
    return (d == 0) ? int'(ifc0.overflow) : int'(ifc1.overflow);
  endfunction
  function automatic int get_busy(input int d);
    return (d == 0) ? int'(ifc0.busy) : int'(ifc1.busy);
  endfunction

  task automatic set_start(input int d, input logic s, input int win);
    if (d == 0) begin ifc0.start = s; ifc0.window = 16'(win); end
    else        begin ifc1.start = s; ifc1.window = 16'(win); end
  endtask

  // Launches one measurement; optionally re-pulses start (window 3) at negedge number poke.
  task automatic do_run(input int d, input int win, input int poke,
                        output int lat, output int pulses, output int ring);
    int d0, r0, se;
    @(posedge clk); #1;
    d0 = d_n[d];
    r0 = ring_n[d];
    set_start(d, 1'b1, win);
    se = edge_n + 1;
    @(posedge clk); #1;
    set_start(d, 1'b0, 0);
    for (int i = 0; i < 400 && d_n[d] == d0; i++) begin
      @(negedge clk);
      if (i == poke)     set_start(d, 1'b1, 3);
      if (i == poke + 1) set_start(d, 1'b0, 0);
    end
    repeat (6) @(negedge clk);
    pulses = d_n[d] - d0;
    ring   = ring_n[d] - r0;
    lat    = d_edge[d] - se;
  endtask

  typedef struct {
    int dut;
    int win;
    int per;
    int lat;
    int cnt;
    int ovf;
    int ring;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, pulses, ring;

    vecs[0] = '{0, 16, 4, 23,  4, 0, 20};
    vecs[1] = '{0,  0, 2,  7,  0, 0,  4};
    vecs[2] = '{0,  8, 4, 15,  2, 0, 12};
    vecs[3] = '{0, 20, 2, 27, 10, 0, 24};
    vecs[4] = '{0, 16, 0, 23,  0, 0, 20};
    vecs[5] = '{1, 40, 2, 47, 15, 1, 44};
    vecs[6] = '{1,  8, 2, 15,  4, 0, 12};
    vecs[7] = '{1, 30, 2, 37, 15, 0, 34};
    vecs[8] = '{1, 32, 2, 39, 15, 1, 36};

    rst_n = 1'b0;
    ifc0.active = 1'b0; ifc0.start = 1'b0; ifc0.window = '0;
    ifc1.active = 1'b0; ifc1.start = 1'b0; ifc1.window = '0;
    repeat (3) @(negedge clk);
    check("rst ring_en", int'(ifc0.ring_en), 0);
    check("rst busy",    int'(ifc0.busy), 0);
    check("rst done",    int'(ifc0.done), 0);
    check("rst count",   int'(ifc0.count), 0);
    check("rst overflow", int'(ifc0.overflow), 0);
    check("rst count1",  int'(ifc1.count), 0);
    rst_n = 1'b1;
    ifc0.active = 1'b1;
    ifc1.active = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      wave_per = vecs[k].per;
      do_run(vecs[k].dut, vecs[k].win, -10, lat, pulses, ring);
      check($sformatf("vec%0d done pulses", k), pulses, 1);
      check($sformatf("vec%0d latency", k), lat, vecs[k].lat);
      check($sformatf("vec%0d count", k), get_cnt(vecs[k].dut), vecs[k].cnt);
      check($sformatf("vec%0d overflow", k), get_ovf(vecs[k].dut), vecs[k].ovf);
      check($sformatf("vec%0d ring cycles", k), ring, vecs[k].ring);
      check($sformatf("vec%0d busy after", k), get_busy(vecs[k].dut), 0);
    end

    // Second start during COUNT must be ignored.
    wave_per = 4;
    do_run(0, 16, 10, lat, pulses, ring);
    check("ignored start pulses", pulses, 1);
    check("ignored start latency", lat, 23);
    check("ignored start count", get_cnt(0), 4);
    check("ignored start ring", ring, 20);

    // Abort mid-COUNT by dropping active.
    @(posedge clk); #1;
    set_start(0, 1'b1, 16);
    @(posedge clk); #1;
    set_start(0, 1'b0, 0);
    repeat (8) @(posedge clk);
    #1;
    check("abort pre busy", int'(ifc0.busy), 1);
    check("abort pre ring_en", int'(ifc0.ring_en), 1);
    pulses = d_n[0];
    ifc0.active = 1'b0;
    @(posedge clk); @(negedge clk);
    check("abort busy", int'(ifc0.busy), 0);
    check("abort ring_en", int'(ifc0.ring_en), 0);
    repeat (30) @(negedge clk);
    check("abort done pulses", d_n[0] - pulses, 0);
    check("abort count held", get_cnt(0), 4);
    ifc0.active = 1'b1;

    // Asynchronous reset during SETTLE clears outputs without a clock edge.
    @(posedge clk); #1;
    set_start(0, 1'b1, 16);
    @(posedge clk); #1;
    set_start(0, 1'b0, 0);
    #2;
    check("midrst pre ring_en", int'(ifc0.ring_en), 1);
    rst_n = 1'b0;
    #1;
    check("midrst ring_en", int'(ifc0.ring_en), 0);
    check("midrst busy", int'(ifc0.busy), 0);
    check("midrst count", int'(ifc0.count), 0);
    check("midrst overflow1", int'(ifc1.overflow), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_run(0, 16, -10, lat, pulses, ring);
    check("post rst pulses", pulses, 1);
    check("post rst latency", lat, 23);
    check("post rst count", get_cnt(0), 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_ring_counter.md
Name: adder_ring_counter

Overview:
- Downstream measurement stage for the instrumented Kogge-Stone adder.
- Enables the adder's ring oscillator and counts rising edges of its asynchronous `chain_out` over a programmable gate window of clock cycles.
- Publishes a held count with a done pulse. The wrapper maps the count onto a logic-analyser output; higher count means shorter adder path delay.

Parameters:
- WIN_W, 16, width of the gate-window length input, in clock cycles.
- CNT_W, 16, width of the edge counter and result.
- SETTLE_CYC, 4, cycles with the ring enabled before counting begins (oscillator start-up); must be >= 1.

Ports:
- wb_clk_i  input  1  sole clock.
- wb_rst_n  input  1  asynchronous active-low reset.
- active  input  1  wrapper enable; low forces IDLE.
- start  input  1  sampled in IDLE; high launches a measurement.
- window  input  WIN_W  gate length in cycles; sampled with start.
- chain_out  input  1  asynchronous ring-oscillator tap from the adder.
- ring_en  output  1  enables the ring oscillator.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a new result is valid.
- count  output  CNT_W  last completed result, held.
- overflow  output  1  last result saturated.

Behaviour:
- Reset: all outputs 0, state IDLE, synchronizer and gate-delay registers 0.
- Reset is asynchronous. Assertion mid-measurement clears everything immediately, including `count`.
- Synchronizer: `chain_out` passes through 2 flops, then a third flop for edge detection. A detected rise is sync2 & ~sync3. Total latency is 3 cycles.
- FSM states: IDLE, SETTLE, COUNT, DRAIN, DONE.
- IDLE:
  - On active & start, latch `window` and go to SETTLE; otherwise stay in IDLE.
  - `start` outside IDLE is ignored.
- SETTLE: `ring_en`=1 for SETTLE_CYC cycles. Then go to COUNT, or straight to DRAIN if the latched window is 0.
- COUNT: `ring_en`=1 for exactly `window` cycles, then go to DRAIN.
- DRAIN: `ring_en`=0 for exactly 3 cycles, which flushes the synchronizer. Then go to DONE.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Timing: `done` rises SETTLE_CYC + window + 3 clock edges after the edge that sampled `start`.
- Gating:
  - The gate signal is (state==COUNT) delayed by 3 cycles, so each counted cycle corresponds exactly to a COUNT-state sample.
  - A rise is counted only when the gate is high.
- Counter:
  - The working counter clears on leaving IDLE.
  - It increments by 1 per gated rise and saturates at 2^CNT_W-1.
  - A sticky saturation flag is set when an increment is attempted at the maximum value.
- Output update: `count` and `overflow` load from the working counter and flag on entry to DONE. They hold until the next DONE or reset. `overflow` therefore clears only at a subsequent non-saturating DONE.
- Abort via `active`:
  - `active` low in any state forces IDLE next cycle with `ring_en`=0.
  - No `done` pulse; `count` and `overflow` keep their previous values.
- `start` and `active` high together in IDLE while `window`=0: the measurement runs and the result is 0.

Test Plan:
- Basic count: drive `chain_out` as a clock-synchronous square wave of period 4 cycles, window=16, SETTLE_CYC=4, then pulse `start` → `done` 23 edges after the start edge; count=4, overflow=0; `ring_en` high for exactly 20 cycles.
- Zero window: window=0, with `chain_out` toggling every cycle → `done` 7 edges after start; count=0; `ring_en` high for 4 cycles.
- Saturation: CNT_W=4, `chain_out` period 2, window=40 → count=15, overflow=1. A follow-up run with window=8 → count=4, overflow=0.
- Ignored start: pulse `start` again during COUNT → no restart, single `done` pulse, result identical to an undisturbed run.
- Abort: drop `active` mid-COUNT after a prior result of 4 → IDLE next cycle, `ring_en`=0, no `done`, count stays 4.
- Reset mid-op: assert `wb_rst_n`=0 asynchronously during SETTLE → `ring_en`, `busy`, `count` and `overflow` go to 0 immediately; after release a new start completes normally.
